bcd_conv_sched: RTL
===================

// Module: bcd_conv_sched
// PURPOSE
//  Shares one serial double-dabble binary-to-BCD engine between NREQ requesters
//  (e.g. seconds, minutes and hours counters feeding the display).
//  Round-robin arbitration; one bit is converted per clock, MSB first.
//  Results go to a shared hun/ten/one output bus, tagged with the requester id.
// PARAMETERS
//  NREQ  3  number of requesters (2..4)
//  W     8  binary operand width; digit outputs fixed at 3 x 4 bits (W<=9)
// PORTS
//  clk      in   1       clock, rising edge
//  rst      in   1       asynchronous reset, active low
//  req      in   NREQ    per-requester request; held high until its grant pulse
//  bin_flat in   NREQ*W  operands, requester k at [k*W +: W]
//  grant    out  NREQ    one-hot, 1-cycle pulse: operand of that requester captured
//  busy     out  1       high while a conversion is in flight (SHIFT or DONE)
//  done     out  1       1-cycle pulse: hun/ten/one valid for done_id
//  done_id  out  2       index of the requester whose result is on hun/ten/one
//  hun      out  4       BCD hundreds digit (registered, held until next done)
//  ten      out  4       BCD tens digit
//  one      out  4       BCD ones digit
// BEHAVIOUR
//  Reset (rst low, any time, including mid-conversion):
//   - state=IDLE; grant, busy, done = 0; done_id, hun, ten, one = 0
//   - RR pointer set so requester 0 has highest priority
//   - in-flight conversion discarded, no done pulse
//  FSM states IDLE, SHIFT, DONE:
//   IDLE: if any req bit at edge N: pick the first set bit at or after ptr,
//     modulo NREQ.
//     - latch its operand into shift reg; clear internal digits; cnt=W
//     - grant<=onehot(k); ptr<=(k+1)%NREQ; state->SHIFT
//     - no req: stay IDLE, all pulses 0
//   SHIFT: each edge performs one double-dabble step:
//     - for each internal digit >=5, add 3 (4-bit wrap, never overflows)
//     - shift {hun,ten,one,opnd} left by 1; cnt--
//     - on the edge where cnt==1, write the final digits to hun/ten/one;
//       done<=1; done_id<=k; state->DONE
//   DONE: done<=0; state->IDLE. One idle edge before next arbitration.
//  Timing:
//   - grant high in cycle after edge N
//   - done high W cycles after grant rises
//   - back-to-back grants are W+2 cycles apart
//  Handshake rules:
//   - operand sampled only at the granting edge; later bin_flat changes ignored
//   - req dropped before grant: request is forgotten, no error
//   - req of granted requester must fall in the grant cycle; a req still high
//     at the next IDLE edge is a new request
//   - reqs arriving while busy wait; arbitration only happens in IDLE
//  Arithmetic:
//   - operand is unsigned
//   - hundreds digit saturates only by range (255 max -> 2)
//   - W=9 values >999 not allowed
//  hun/ten/one change only on the done edge; stable at all other times.
// TESTING
//  1 - req=001, operand0=59
//      -> grant=001 one cycle; done 8 cycles later; hun=0, ten=5, one=9, done_id=0
//  2 - operands 0 and 255
//      -> 0/0/0 and 2/5/5; also check 99 -> 0/9/9 and 100 -> 1/0/0
//  3 - req=111 held continuously from reset
//      -> grants in order 001, 010, 100, 001; grant rises every 10 cycles
//      -> done_id sequence 0, 1, 2, 0
//  4 - req1 asserted while busy serving req0, bin_flat changed mid-conversion
//      -> req0's result unaffected; req1 granted on the first IDLE edge
//  5 - rst pulsed low during SHIFT
//      -> all outputs 0 immediately; no done pulse
//      -> after release, req=010 is served with requester 1 (ptr back at 0)
//  6 - req0 pulsed for one cycle while busy, low before IDLE
//      -> never granted, no done for id 0

Source files
------------

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched
//   Shares one serial double-dabble binary-to-BCD engine between NREQ
//   requesters using round-robin arbitration. The engine converts one operand
//   bit per clock, MSB first. Each result appears on a shared hundreds/tens/ones
//   bus together with the id of the requester that produced it.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   req_i        per-requester request, held high until its grant pulse
//   bin_flat_i   operands; requester k occupies [k*W +: W]
//   grant_o      one-hot, 1-cycle pulse: that requester's operand was captured
//   busy_o       high while a conversion is in flight (SHIFT or DONE)
//   done_o       1-cycle pulse: hun_o/ten_o/one_o are valid for done_id_o
//   done_id_o    index of the requester whose result is on the digit bus
//   hun_o        BCD hundreds digit, held until the next done
//   ten_o        BCD tens digit
//   one_o        BCD ones digit
module bcd_conv_sched #(
  parameter int NREQ = 3,
  parameter int W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] bin_flat_i,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        done_id_o,
  output logic [3:0]        hun_o,
  output logic [3:0]        ten_o,
  output logic [3:0]        one_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      sel_q, sel_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [11:0]     dig_q, dig_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            done_q, done_d;
  logic [1:0]      done_id_q, done_id_d;
  logic [11:0]     res_q, res_d;

  // Digits after the "add 3 if >= 5" correction. A corrected digit is at most
  // 12, so the 4-bit add never wraps.
  logic [11:0] adj;
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (dig_q[gi*4 +: 4] >= 4'd5) ? dig_q[gi*4 +: 4] + 4'd3
                                                           : dig_q[gi*4 +: 4];
    end
  endgenerate

  // Next digit value after one step: corrected digits shifted left, with the
  // operand MSB entering the ones digit.
  logic [11:0] step_dig;
  assign step_dig = (adj << 1) | {11'd0, opnd_q[W-1]};

  // Round-robin pick: first requester at or after ptr_q, wrapping modulo NREQ.
  logic         any_req;
  logic [1:0]   pick;
  logic [W-1:0] pick_opnd;
  int           idx;
  always_comb begin
    any_req   = 1'b0;
    pick      = ptr_q;
    pick_opnd = '0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!any_req && req_i[idx]) begin
        any_req   = 1'b1;
        pick      = 2'(idx);
        pick_opnd = bin_flat_i[idx*W +: W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    opnd_d    = opnd_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    grant_d   = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    res_d     = res_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          opnd_d  = pick_opnd;
          dig_d   = '0;
          cnt_d   = 4'(W);
          sel_d   = pick;
          grant_d = NREQ'(1) << pick;
          ptr_d   = 2'((int'(pick) + 1) % NREQ);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        dig_d  = step_dig;
        opnd_d = opnd_q << 1;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_d     = step_dig;
          done_d    = 1'b1;
          done_id_d = sel_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        // One dead cycle before the next arbitration round.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      opnd_q    <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      opnd_q    <= opnd_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      res_q     <= res_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign done_id_o = done_id_q;
  assign hun_o     = res_q[11:8];
  assign ten_o     = res_q[7:4];
  assign one_o     = res_q[3:0];

endmodule
